// File: rtl/full_handshake_tx_if.sv
// Bundles the local send/status signals and the cross-domain req/ack/data wires of the TX handshake.
// master is the TX block's view; slave is the view of whatever sits around it (local logic + RX side).
interface full_handshake_tx_if #(
    parameter int DW = 32
);
    logic          send_i;
    logic [DW-1:0] send_data_i;
    logic          busy_o;
    logic          done_o;
    logic          ack_i;
    logic          req_o;
    logic [DW-1:0] req_data_o;

    modport master (
        input  send_i,
        input  send_data_i,
        input  ack_i,
        output busy_o,
        output done_o,
        output req_o,
        output req_data_o
    );

    modport slave (
        output send_i,
        output send_data_i,
        output ack_i,
        input  busy_o,
        input  done_o,
        input  req_o,
        input  req_data_o
    );
endinterface

// File: rtl/full_handshake_tx.sv
// Four-phase CDC handshake, TX side: captures a word on send, drives req/data until ack, pulses done once ack clears.
// req_o rises 1 clk after an accepted send; send_i is dropped (not queued) while busy_o is high.
module full_handshake_tx #(
    parameter int DW = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    full_handshake_tx_if.master bus
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ASSERT   = 2'd1,
        DEASSERT = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic          ack_d, ack_s;
    logic          req_q, req_nxt;
    logic [DW-1:0] req_data_q, req_data_nxt;
    logic          done_q, done_nxt;

    // ack_i belongs to the RX clock domain; nothing but ack_s may steer the FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_d <= 1'b0;
            ack_s <= 1'b0;
        end else begin
            ack_d <= bus.ack_i;
            ack_s <= ack_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            req_q      <= 1'b0;
            req_data_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state      <= state_nxt;
            req_q      <= req_nxt;
            req_data_q <= req_data_nxt;
            done_q     <= done_nxt;
        end
    end

    // Data is only reloaded on acceptance, so it stays stable around the RX sampling point.
    always_comb begin
        state_nxt    = state;
        req_nxt      = req_q;
        req_data_nxt = req_data_q;
        done_nxt     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.send_i && !ack_s) begin
                    req_nxt      = 1'b1;
                    req_data_nxt = bus.send_data_i;
                    state_nxt    = ASSERT;
                end
            end
            ASSERT: begin
                if (ack_s) begin
                    req_nxt   = 1'b0;
                    state_nxt = DEASSERT;
                end
            end
            DEASSERT: begin
                if (!ack_s) begin
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                req_nxt   = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    // A lingering ack (e.g. after a reset mid-transfer) keeps us busy so no half handshake starts.
    assign bus.busy_o     = (state != IDLE) | ack_s;
    assign bus.done_o     = done_q;
    assign bus.req_o      = req_q;
    assign bus.req_data_o = req_data_q;

endmodule

// File: tb/tb_full_handshake_tx.sv
// Directed bench for full_handshake_tx: per-cycle transaction-level model plus literal timing checks.
module tb_full_handshake_tx;

    localparam int DW = 32;

    logic clk    = 1'b0;
    logic rx_clk = 1'b0;
    logic rst_n  = 1'b0;
    int   clk_half = 5;
    int   rx_half  = 5;

    int tests = 0;
    int fails = 0;

    logic rx_en   = 1'b0;
    logic man_ack = 1'b0;
    logic rx_ack;
    logic chk_en  = 1'b0;

    full_handshake_tx_if #(.DW(DW)) bus ();

    full_handshake_tx #(.DW(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign bus.ack_i = rx_en ? rx_ack : man_ack;

    initial forever #(clk_half) clk = ~clk;
    initial forever #(rx_half) rx_clk = ~rx_clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // RX-side responder: two-flop req sync, acks each new request, releases after req drops.
    logic          rq_d, rq_s;
    logic [DW-1:0] rx_q[$];
    int            rx_cnt = 0;
    always @(posedge rx_clk) begin
        if (!rx_en) begin
            rq_d   <= 1'b0;
            rq_s   <= 1'b0;
            rx_ack <= 1'b0;
        end else begin
            rq_d <= bus.req_o;
            rq_s <= rq_d;
            if (rq_s && !rx_ack) begin
                rx_ack <= 1'b1;
                rx_q.push_back(bus.req_data_o);
                rx_cnt <= rx_cnt + 1;
            end else if (!rq_s && rx_ack) begin
                rx_ack <= 1'b0;
            end
        end
    end

    // Transaction model: a transfer is "open" from acceptance until the synced ack has come and gone.
    logic [1:0]    m_ah;
    logic          m_open, m_acked, m_done;
    logic [DW-1:0] m_data;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ah    <= 2'b00;
            m_open  <= 1'b0;
            m_acked <= 1'b0;
            m_done  <= 1'b0;
            m_data  <= '0;
        end else begin
            m_ah   <= {m_ah[0], bus.ack_i};
            m_done <= 1'b0;
            if (!m_open) begin
                if (bus.send_i && !m_ah[1]) begin
                    m_open  <= 1'b1;
                    m_acked <= 1'b0;
                    m_data  <= bus.send_data_i;
                end
            end else if (!m_acked) begin
                if (m_ah[1]) m_acked <= 1'b1;
            end else if (!m_ah[1]) begin
                m_open <= 1'b0;
                m_done <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_req_o",      bus.req_o,      m_open && !m_acked);
            check("model_busy_o",     bus.busy_o,     m_open || m_ah[1]);
            check("model_done_o",     bus.done_o,     m_done);
            check("model_req_data_o", bus.req_data_o, m_data);
        end
    end

    int   done_cnt = 0;
    int   rise_cnt = 0;
    logic prev_req = 1'b0;
    always @(negedge clk) begin
        if (bus.done_o) done_cnt <= done_cnt + 1;
        if (bus.req_o && !prev_req) rise_cnt <= rise_cnt + 1;
        prev_req <= bus.req_o;
    end

    task automatic send_word(input logic [DW-1:0] w);
        bus.send_i      = 1'b1;
        bus.send_data_i = w;
        @(negedge clk);
        bus.send_i      = 1'b0;
        bus.send_data_i = ~w;
    endtask

    // Manual RX: ack d_up clk after req is seen, drop it d_dn clk after req falls.
    task automatic man_rx(input int d_up, input int d_dn, output int fall_n);
        int w;
        w = 0;
        while (!bus.req_o && w < 50) begin @(negedge clk); w++; end
        if (!bus.req_o) check("man_rx_req_timeout", 0, 1);
        repeat (d_up) @(negedge clk);
        man_ack = 1'b1;
        fall_n = 0;
        while (bus.req_o && fall_n < 30) begin @(negedge clk); fall_n++; end
        repeat (d_dn) @(negedge clk);
        man_ack = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (bus.done_o) seen = 1'b1;
        end
        check(name, seen, 1);
    endtask

    task automatic wait_idle(input string name);
        int w;
        w = 0;
        while (bus.busy_o && w < 300) begin @(negedge clk); w++; end
        check(name, bus.busy_o, 0);
    endtask

    initial begin
        int n, d0, r0, bcnt, qcnt;
        logic [DW-1:0] sent_q[$];
        logic [DW-1:0] w;

        bus.send_i      = 1'b0;
        bus.send_data_i = '0;
        repeat (3) @(negedge clk);
        check("reset_busy_o",     bus.busy_o,     0);
        check("reset_done_o",     bus.done_o,     0);
        check("reset_req_o",      bus.req_o,      0);
        check("reset_req_data_o", bus.req_data_o, 0);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);

        // Basic transfer
        d0 = done_cnt;
        send_word(32'hDEADBEEF);
        check("basic_req_next_cycle", bus.req_o,      1);
        check("basic_data",           bus.req_data_o, 32'hDEADBEEF);
        check("basic_busy",           bus.busy_o,     1);
        man_rx(3, 3, n);
        check("basic_req_fall_edges", n, 3);
        wait_done("basic_done_seen");
        @(negedge clk);
        check("basic_done_one_cycle", bus.done_o,     0);
        check("basic_busy_after",     bus.busy_o,     0);
        check("basic_data_kept",      bus.req_data_o, 32'hDEADBEEF);
        check("basic_done_count",     done_cnt - d0,  1);

        // Busy drop
        d0 = done_cnt; r0 = rise_cnt;
        send_word(32'h1);
        bus.send_i      = 1'b1;
        bus.send_data_i = 32'h2;
        repeat (2) @(negedge clk);
        bus.send_i = 1'b0;
        man_rx(3, 3, n);
        wait_done("drop_done_seen");
        repeat (3) @(negedge clk);
        check("drop_data_kept",   bus.req_data_o, 32'h1);
        check("drop_req_pulses",  rise_cnt - r0,  1);
        check("drop_done_pulses", done_cnt - d0,  1);

        // Back-to-back with the automatic RX responder
        rx_q.delete();
        rx_en = 1'b1;
        send_word(32'h12345678);
        wait_done("b2b_first_done");
        bus.send_i      = 1'b1;
        bus.send_data_i = 32'hA5A5A5A5;
        @(negedge clk);
        bus.send_i = 1'b0;
        check("b2b_req",  bus.req_o,      1);
        check("b2b_data", bus.req_data_o, 32'hA5A5A5A5);
        wait_done("b2b_second_done");
        check("b2b_rx_count", rx_q.size(), 2);
        if (rx_q.size() == 2) begin
            check("b2b_rx_word0", rx_q[0], 32'h12345678);
            check("b2b_rx_word1", rx_q[1], 32'hA5A5A5A5);
        end
        repeat (2) @(negedge clk);
        rx_en = 1'b0;
        @(negedge clk);

        // Reset mid-transfer with ack still held by the RX side
        send_word(32'h77);
        repeat (2) @(negedge clk);
        man_ack = 1'b1;
        @(negedge clk);
        check("rst_req_before", bus.req_o, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_req_immediate",  bus.req_o,      0);
        check("rst_data_immediate", bus.req_data_o, 0);
        check("rst_done_immediate", bus.done_o,     0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_busy_from_ack", bus.busy_o, 1);
        bus.send_i      = 1'b1;
        bus.send_data_i = 32'h55;
        repeat (3) @(negedge clk);
        check("rst_send_blocked", bus.req_o, 0);
        man_ack = 1'b0;
        n = 0;
        while (bus.busy_o && n < 20) begin @(negedge clk); n++; end
        check("rst_busy_fall_edges", n, 2);
        @(negedge clk);
        bus.send_i = 1'b0;
        check("rst_send_accepted", bus.req_o,      1);
        check("rst_send_data",     bus.req_data_o, 32'h55);
        man_rx(3, 3, n);
        wait_done("rst_done_seen");
        @(negedge clk);

        // Stale ack in IDLE
        d0 = done_cnt; r0 = rise_cnt; bcnt = 0; qcnt = 0;
        man_ack = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 3) man_ack = 1'b0;
            if (bus.busy_o) bcnt++;
            if (bus.req_o) qcnt++;
        end
        check("stale_busy_cycles", bcnt, 4);
        check("stale_req_cycles",  qcnt, 0);
        check("stale_req_rises",   rise_cnt - r0, 0);
        check("stale_done",        done_cnt - d0, 0);

        // Async clocks: TX slower and faster than RX
        for (int cfg = 0; cfg < 2; cfg++) begin
            clk_half = (cfg == 0) ? 5 : 15;
            rx_half  = (cfg == 0) ? 15 : 5;
            rx_q.delete();
            sent_q.delete();
            d0 = done_cnt;
            r0 = rx_cnt;
            rx_en = 1'b1;
            @(negedge clk);
            for (int k = 0; k < 100; k++) begin
                wait_idle("async_wait_idle");
                w = $urandom;
                sent_q.push_back(w);
                send_word(w);
            end
            n = 0;
            while ((done_cnt - d0) < 100 && n < 500) begin @(negedge clk); n++; end
            repeat (4) @(negedge clk);
            check("async_done_pulses", done_cnt - d0, 100);
            check("async_rx_pulses",   rx_cnt - r0,   100);
            check("async_rx_count",    rx_q.size(),   100);
            if (rx_q.size() == 100) begin
                for (int k = 0; k < 100; k++) check("async_word_order", rx_q[k], sent_q[k]);
            end
            rx_en = 1'b0;
            repeat (4) @(negedge clk);
        end

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5000000;
        fails++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
